// File: rtl/niu_tx_arbiter.sv
// Frame-granular arbiter sharing the NIU 10G MAC TX AXI-Stream path between NUM_REQ requesters.
// Round-robin by default; define NIU_TX_ARB_STRICT_PRIO_EN for strict lowest-index-first priority.
`timescale 1ns/1ps

module niu_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int SEL_W   = 2
) (
    input  logic                    clk156,
    input  logic                    reset,
    input  logic [NUM_REQ*64-1:0]   s_axis_tdata,
    input  logic [NUM_REQ*8-1:0]    s_axis_tkeep,
    input  logic [NUM_REQ-1:0]      s_axis_tvalid,
    input  logic [NUM_REQ-1:0]      s_axis_tlast,
    output logic [NUM_REQ-1:0]      s_axis_tready,
    output logic [63:0]             m_axis_tdata,
    output logic [7:0]              m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    busy,
    output logic [31:0]             tx_pkt_count
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     last_q, last_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [31:0]          tx_pkt_count_q, tx_pkt_count_d;

    logic [SEL_W-1:0]     win_idx;
    logic                 win_found;
    logic                 sel_valid;
    logic                 sel_last;
    int                   rr_idx;

    // Winner of the next arbitration, evaluated only while IDLE.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        rr_idx    = 0;
`ifdef NIU_TX_ARB_STRICT_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                win_idx   = SEL_W'(i);
                win_found = 1'b1;
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = int'(last_q) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!win_found && s_axis_tvalid[rr_idx]) begin
                win_idx   = SEL_W'(rr_idx);
                win_found = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_q == SEL_W'(i)) begin
                m_axis_tdata = s_axis_tdata[i*64 +: 64];
                m_axis_tkeep = s_axis_tkeep[i*8 +: 8];
                sel_valid    = s_axis_tvalid[i];
                sel_last     = s_axis_tlast[i];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        last_d         = last_q;
        grant_d        = grant_q;
        tx_pkt_count_d = tx_pkt_count_q;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        s_axis_tready  = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    grant_d = NUM_REQ'(1) << win_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_axis_tvalid = sel_valid;
                m_axis_tlast  = sel_last;
                s_axis_tready = grant_q & {NUM_REQ{m_axis_tready}};
                // The grant is released only on the accepted tlast beat.
                if (sel_valid && m_axis_tready && sel_last) begin
                    state_d        = IDLE;
                    grant_d        = '0;
                    tx_pkt_count_d = tx_pkt_count_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            last_q         <= SEL_W'(NUM_REQ - 1);
            grant_q        <= '0;
            tx_pkt_count_q <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            last_q         <= last_d;
            grant_q        <= grant_d;
            tx_pkt_count_q <= tx_pkt_count_d;
        end
    end

    assign grant        = grant_q;
    assign busy         = (state_q == XFER);
    assign tx_pkt_count = tx_pkt_count_q;

endmodule

// File: tb/tb_niu_tx_arbiter.sv
// Randomized self-checking bench for niu_tx_arbiter against a frame-level arbitration model.
// Honours NIU_TX_ARB_STRICT_PRIO_EN when predicting the frame order.
`timescale 1ns/1ps

module tb_niu_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int SEL_W   = 2;

    logic                  clk156 = 1'b0;
    logic                  reset  = 1'b1;
    logic [NUM_REQ*64-1:0] s_axis_tdata  = '0;
    logic [NUM_REQ*8-1:0]  s_axis_tkeep  = '0;
    logic [NUM_REQ-1:0]    s_axis_tvalid = '0;
    logic [NUM_REQ-1:0]    s_axis_tlast  = '0;
    logic [NUM_REQ-1:0]    s_axis_tready;
    logic [63:0]           m_axis_tdata;
    logic [7:0]            m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready = 1'b0;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic [31:0]           tx_pkt_count;

    niu_tx_arbiter #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) dut (
        .clk156(clk156), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .grant(grant), .busy(busy), .tx_pkt_count(tx_pkt_count)
    );

    always #5 clk156 = ~clk156;

    int n_cmp = 0;
    int n_err = 0;

    // Source-side beats still to be offered by each requester.
    logic [63:0] src_data [NUM_REQ][$];
    logic [7:0]  src_keep [NUM_REQ][$];
    logic        src_last [NUM_REQ][$];
    // Model copies of the same frames, consumed when the expectation is built.
    logic [63:0] mdl_data [NUM_REQ][$];
    logic [7:0]  mdl_keep [NUM_REQ][$];
    logic        mdl_last [NUM_REQ][$];
    int          frame_len [NUM_REQ][$];
    // Expected master-side beat stream and the requester owning each beat.
    logic [63:0] exp_data [$];
    logic [7:0]  exp_keep [$];
    logic        exp_last [$];
    int          exp_owner [$];
    int          obs_owner [$];
    int          model_last;
    int          exp_frames;

    task automatic clear_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_data[i].delete(); src_keep[i].delete(); src_last[i].delete();
            mdl_data[i].delete(); mdl_keep[i].delete(); mdl_last[i].delete();
            frame_len[i].delete();
        end
        exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_owner.delete();
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk156);
        clear_all();
        m_axis_tready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk156);
        reset = 1'b0;
        model_last = NUM_REQ - 1;
    endtask

    task automatic load_frame(input int req, input int len);
        logic [63:0] d;
        logic [7:0]  k;
        for (int b = 0; b < len; b++) begin
            d = {$urandom, $urandom};
            k = (b == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
            src_data[req].push_back(d); src_keep[req].push_back(k); src_last[req].push_back(b == len - 1);
            mdl_data[req].push_back(d); mdl_keep[req].push_back(k); mdl_last[req].push_back(b == len - 1);
        end
        frame_len[req].push_back(len);
    endtask

    // Every requester with a pending frame is valid whenever the arbiter is idle,
    // so the frame order follows directly from the selection rule.
    task automatic build_expectation();
        int w;
        int len;
        exp_frames = 0;
        forever begin
            w = -1;
`ifdef NIU_TX_ARB_STRICT_PRIO_EN
            for (int i = NUM_REQ - 1; i >= 0; i--)
                if (frame_len[i].size() != 0) w = i;
`else
            for (int k = 1; k <= NUM_REQ; k++)
                if (w < 0 && frame_len[(model_last + k) % NUM_REQ].size() != 0)
                    w = (model_last + k) % NUM_REQ;
`endif
            if (w < 0) break;
            model_last = w;
            exp_frames++;
            len = frame_len[w].pop_front();
            for (int b = 0; b < len; b++) begin
                exp_data.push_back(mdl_data[w].pop_front());
                exp_keep.push_back(mdl_keep[w].pop_front());
                exp_last.push_back(mdl_last[w].pop_front());
                exp_owner.push_back(w);
            end
        end
    endtask

    task automatic drive_sources();
        logic [NUM_REQ*64-1:0] d;
        logic [NUM_REQ*8-1:0]  k;
        logic [NUM_REQ-1:0]    v;
        logic [NUM_REQ-1:0]    l;
        d = '0; k = '0; v = '0; l = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_data[i].size() != 0) begin
                v[i] = 1'b1;
                d[i*64 +: 64] = src_data[i][0];
                k[i*8 +: 8]   = src_keep[i][0];
                l[i]          = src_last[i][0];
            end else begin
                d[i*64 +: 64] = {$urandom, $urandom};
                l[i]          = 1'($urandom);
            end
        end
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tvalid = v; s_axis_tlast = l;
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1.
    task automatic run_frames(input int ready_mode, input logic [31:0] base, input string tag);
        int cyc = 0;
        int tail = 0;
        bit exp_idle = 1'b1;
        bit prev_zero = 1'b1;
        int owner;
        logic [NUM_REQ-1:0] exp_grant;
        build_expectation();
        obs_owner.delete();
        forever begin
            if (cyc >= 4000) begin
                n_cmp++; n_err++;
                $display("[TB] FAIL %s timeout: %0d beats outstanding, required 0", tag, exp_data.size());
                break;
            end
            @(negedge clk156);
            drive_sources();
            case (ready_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ($urandom_range(0, 3) != 0);
                default: m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            #1;
            cyc++;
            if (prev_zero && grant != '0)
                for (int i = 0; i < NUM_REQ; i++) if (grant[i]) obs_owner.push_back(i);
            prev_zero = (grant == '0);
            if (exp_idle) begin
                n_cmp++;
                if (grant !== '0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || busy !== 1'b0) begin
                    n_err++;
                    $display("[TB] FAIL %s idle: grant=%b tvalid=%b tready=%b busy=%b, required 0/0/0/0",
                             tag, grant, m_axis_tvalid, s_axis_tready, busy);
                end
                if (exp_data.size() == 0) begin
                    tail++;
                    if (tail >= 2) break;
                end else begin
                    exp_idle = 1'b0;
                end
            end else begin
                owner = exp_owner[0];
                exp_grant = NUM_REQ'(1) << owner;
                n_cmp++;
                if (grant !== exp_grant || busy !== 1'b1 || m_axis_tvalid !== 1'b1) begin
                    n_err++;
                    $display("[TB] FAIL %s grant: grant=%b busy=%b tvalid=%b, required %b/1/1",
                             tag, grant, busy, m_axis_tvalid, exp_grant);
                end
                n_cmp++;
                if (s_axis_tready !== (m_axis_tready ? exp_grant : '0)) begin
                    n_err++;
                    $display("[TB] FAIL %s s_tready: got %b, required %b", tag, s_axis_tready,
                             m_axis_tready ? exp_grant : '0);
                end
                if (m_axis_tready) begin
                    n_cmp++;
                    if (m_axis_tdata !== exp_data[0] || m_axis_tkeep !== exp_keep[0] || m_axis_tlast !== exp_last[0]) begin
                        n_err++;
                        $display("[TB] FAIL %s beat: got %h/%h/%b, required %h/%h/%b", tag,
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, exp_data[0], exp_keep[0], exp_last[0]);
                    end
                    if (exp_last[0]) exp_idle = 1'b1;
                    void'(exp_data.pop_front()); void'(exp_keep.pop_front());
                    void'(exp_last.pop_front()); void'(exp_owner.pop_front());
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (s_axis_tvalid[i] && s_axis_tready[i] && src_data[i].size() != 0) begin
                    void'(src_data[i].pop_front()); void'(src_keep[i].pop_front()); void'(src_last[i].pop_front());
                end
            end
        end
        n_cmp++;
        if (tx_pkt_count !== base + 32'(exp_frames)) begin
            n_err++;
            $display("[TB] FAIL %s count: got %h, required %h", tag, tx_pkt_count, base + 32'(exp_frames));
        end
        clear_all();
    endtask

    task automatic test_reset();
        @(negedge clk156);
        reset = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) begin
            @(negedge clk156);
            s_axis_tvalid = NUM_REQ'($urandom);
            s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            n_cmp++;
            if (grant !== '0 || busy !== 1'b0 || tx_pkt_count !== 32'd0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== '0) begin
                n_err++;
                $display("[TB] FAIL reset: grant=%b busy=%b count=%h tvalid=%b tready=%b, required all 0",
                         grant, busy, tx_pkt_count, m_axis_tvalid, s_axis_tready);
            end
        end
        do_reset();
    endtask

    task automatic test_single_frame();
        do_reset();
        load_frame(0, 4);
        run_frames(0, 32'd0, "single");
        n_cmp++;
        if (obs_owner.size() != 1 || obs_owner[0] != 0) begin
            n_err++;
            $display("[TB] FAIL single owner: got %0d grants first=%0d, required 1 grant to 0",
                     obs_owner.size(), obs_owner.size() != 0 ? obs_owner[0] : -1);
        end
    endtask

    task automatic test_alternate();
        int want [4];
`ifdef NIU_TX_ARB_STRICT_PRIO_EN
        want = '{0, 0, 1, 1};
`else
        want = '{0, 1, 0, 1};
`endif
        do_reset();
        for (int f = 0; f < 2; f++) begin
            load_frame(0, 3);
            load_frame(1, 3);
        end
        run_frames(0, 32'd0, "alternate");
        for (int f = 0; f < 4; f++) begin
            n_cmp++;
            if (obs_owner.size() <= f || obs_owner[f] != want[f]) begin
                n_err++;
                $display("[TB] FAIL alternate order[%0d]: got %0d, required %0d", f,
                         obs_owner.size() > f ? obs_owner[f] : -1, want[f]);
            end
        end
    endtask

    task automatic test_back_to_back_backpressure();
        do_reset();
        load_frame(1, 5);
        load_frame(0, 5);
        run_frames(2, 32'd0, "backpressure");
    endtask

    task automatic test_reset_midframe();
        int beats = 0;
        do_reset();
        load_frame(0, 6);
        for (int c = 0; c < 20 && beats < 1; c++) begin
            @(negedge clk156);
            drive_sources();
            m_axis_tready = 1'b1;
            #1;
            if (s_axis_tvalid[0] && s_axis_tready[0]) begin
                beats++;
                void'(src_data[0].pop_front()); void'(src_keep[0].pop_front()); void'(src_last[0].pop_front());
            end
        end
        @(negedge clk156);
        drive_sources();
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mdl_data[0][1]) begin
            n_err++;
            $display("[TB] FAIL midframe beat2: tvalid=%b data=%h, required 1/%h", m_axis_tvalid, m_axis_tdata, mdl_data[0][1]);
        end
        reset = 1'b1;
        @(negedge clk156);
        #1;
        n_cmp++;
        if (grant !== '0 || m_axis_tvalid !== 1'b0 || tx_pkt_count !== 32'd0 || busy !== 1'b0 || s_axis_tready !== '0) begin
            n_err++;
            $display("[TB] FAIL midframe reset: grant=%b tvalid=%b count=%h busy=%b, required 0/0/0/0",
                     grant, m_axis_tvalid, tx_pkt_count, busy);
        end
        clear_all();
        reset = 1'b0;
        model_last = NUM_REQ - 1;
        load_frame(1, 4);
        run_frames(0, 32'd0, "after_reset");
    endtask

    task automatic test_count_wrap();
        do_reset();
        @(negedge clk156);
        force dut.tx_pkt_count_q = 32'hFFFF_FFFF;
        @(negedge clk156);
        release dut.tx_pkt_count_q;
        load_frame(1, 2);
        run_frames(0, 32'hFFFF_FFFF, "wrap");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            do_reset();
            for (int i = 0; i < NUM_REQ; i++)
                for (int f = 0; f < int'($urandom_range(0, 3)); f++)
                    load_frame(i, $urandom_range(1, 6));
            run_frames(1, 32'd0, "random");
        end
    endtask

    initial begin
        model_last = NUM_REQ - 1;
        test_reset();
        test_single_frame();
        test_alternate();
        test_back_to_back_backpressure();
        test_reset_midframe();
        test_count_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
